// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared states and constants for the trap controller
package trap_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int CAUSE_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE,
    ST_VECTOR,
    ST_RETURN
  } trap_state_e;

  localparam int CAUSE_ILLEGAL    = 2;
  localparam int CAUSE_BREAKPOINT = 3;
  localparam int CAUSE_ECALL_M    = 11;
  localparam int IRQ_MTI          = 7;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

endpackage

// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - pipeline/CSR-side signal bundle of the trap controller
interface trap_controller_if #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 6
);
  logic               i_exc_valid;
  logic [CAUSE_W-1:0] i_exc_cause;
  logic [XLEN-1:0]    i_exc_pc;
  logic               i_mret;
  logic [XLEN-1:0]    i_retire_pc;
  logic               i_pipe_idle;
  logic               i_halted;
  logic [XLEN-1:0]    i_mtvec;
  logic [XLEN-1:0]    i_mepc;
  logic [XLEN-1:0]    i_mie;
  logic [XLEN-1:0]    i_mip;
  logic               i_mstatus_mie;
  logic [XLEN-1:0]    o_mepc_data;
  logic               o_mepc_we;
  logic [XLEN-1:0]    o_mcause_data;
  logic               o_mcause_we;
  logic               o_mie_clear;
  logic               o_mie_restore;
  logic               o_stall;
  logic               o_flush;
  logic               o_redirect;
  logic [XLEN-1:0]    o_redirect_pc;
  logic               o_busy;

  modport slave (
    input  i_exc_valid, i_exc_cause, i_exc_pc, i_mret, i_retire_pc, i_pipe_idle,
           i_halted, i_mtvec, i_mepc, i_mie, i_mip, i_mstatus_mie,
    output o_mepc_data, o_mepc_we, o_mcause_data, o_mcause_we, o_mie_clear,
           o_mie_restore, o_stall, o_flush, o_redirect, o_redirect_pc, o_busy
  );

  modport master (
    output i_exc_valid, i_exc_cause, i_exc_pc, i_mret, i_retire_pc, i_pipe_idle,
           i_halted, i_mtvec, i_mepc, i_mie, i_mip, i_mstatus_mie,
    input  o_mepc_data, o_mepc_we, o_mcause_data, o_mcause_we, o_mie_clear,
           o_mie_restore, o_stall, o_flush, o_redirect, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/trap_vector_calc.sv
// rtl/trap_vector_calc.sv - trap handler target PC from mtvec, cause code and interrupt flag
module trap_vector_calc
  import trap_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int CAUSE_W = CAUSE_W_DEF
) (
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic [CAUSE_W-1:0] i_cause_code,
  input  logic               i_is_irq,
  output logic [XLEN-1:0]    o_target
);
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_offset;

  assign w_base   = {i_mtvec[XLEN-1:2], 2'b00};
  assign w_offset = {{(XLEN-CAUSE_W-2){1'b0}}, i_cause_code, 2'b00};

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign o_target = (i_is_irq && (i_mtvec[1:0] == MTVEC_MODE_VECTORED)) ?
                    (w_base + w_offset) : w_base;
endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - trap entry/return sequencer between retire stage and CSR file
module trap_controller
  import trap_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int CAUSE_W = CAUSE_W_DEF
) (
  input logic               i_clk,
  input logic               i_reset,
  trap_controller_if.slave  bus
);
  localparam logic [XLEN-1:0] IRQ_CAUSE =
    {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, CAUSE_W'(IRQ_MTI)};

  trap_state_e     r_state, w_state_nx;
  logic [XLEN-1:0] r_cause, w_cause_nx;
  logic [XLEN-1:0] r_epc, w_epc_nx;
  logic            r_is_irq, w_is_irq_nx;

  logic [XLEN-1:0] r_mepc_data, w_mepc_data_nx;
  logic [XLEN-1:0] r_mcause_data, w_mcause_data_nx;
  logic [XLEN-1:0] r_redirect_pc, w_redirect_pc_nx;
  logic            r_mepc_we, w_mepc_we_nx;
  logic            r_mcause_we, w_mcause_we_nx;
  logic            r_mie_clear, w_mie_clear_nx;
  logic            r_mie_restore, w_mie_restore_nx;
  logic            r_stall, w_stall_nx;
  logic            r_flush, w_flush_nx;
  logic            r_redirect, w_redirect_nx;
  logic            r_busy;

  logic            w_irq_pending;
  logic [XLEN-1:0] w_vec_target;
  logic            w_unused_bits;

  // Only the machine timer interrupt is wired; the other enable/pending bits are ignored.
  assign w_irq_pending = bus.i_mstatus_mie & bus.i_mie[IRQ_MTI] & bus.i_mip[IRQ_MTI];
  assign w_unused_bits = ^{bus.i_mie[XLEN-1:IRQ_MTI+1], bus.i_mie[IRQ_MTI-1:0],
                           bus.i_mip[XLEN-1:IRQ_MTI+1], bus.i_mip[IRQ_MTI-1:0]};

  trap_vector_calc #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) u_vector_calc (
    .i_mtvec      (bus.i_mtvec),
    .i_cause_code (r_cause[CAUSE_W-1:0]),
    .i_is_irq     (r_is_irq),
    .o_target     (w_vec_target)
  );

  always_comb begin
    w_state_nx       = r_state;
    w_cause_nx       = r_cause;
    w_epc_nx         = r_epc;
    w_is_irq_nx      = r_is_irq;
    w_mepc_data_nx   = '0;
    w_mcause_data_nx = '0;
    w_redirect_pc_nx = '0;
    w_mepc_we_nx     = 1'b0;
    w_mcause_we_nx   = 1'b0;
    w_mie_clear_nx   = 1'b0;
    w_mie_restore_nx = 1'b0;
    w_stall_nx       = 1'b0;
    w_flush_nx       = 1'b0;
    w_redirect_nx    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.i_halted) begin
          w_state_nx = ST_IDLE;
        end else if (bus.i_exc_valid) begin
          w_cause_nx  = {{(XLEN-CAUSE_W){1'b0}}, bus.i_exc_cause};
          w_epc_nx    = bus.i_exc_pc;
          w_is_irq_nx = 1'b0;
          w_flush_nx  = 1'b1;
          w_stall_nx  = 1'b1;
          w_state_nx  = ST_SAVE;
        end else if (bus.i_mret) begin
          w_flush_nx       = 1'b1;
          w_stall_nx       = 1'b1;
          w_mie_restore_nx = 1'b1;
          w_redirect_nx    = 1'b1;
          w_redirect_pc_nx = bus.i_mepc;
          w_state_nx       = ST_RETURN;
        end else if (w_irq_pending) begin
          w_cause_nx  = IRQ_CAUSE;
          w_is_irq_nx = 1'b1;
          w_stall_nx  = 1'b1;
          w_state_nx  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_stall_nx = 1'b1;
        // A late exception preempts the interrupt; the interrupt stays pending in the CSRs.
        if (bus.i_exc_valid) begin
          w_cause_nx  = {{(XLEN-CAUSE_W){1'b0}}, bus.i_exc_cause};
          w_epc_nx    = bus.i_exc_pc;
          w_is_irq_nx = 1'b0;
          w_flush_nx  = 1'b1;
          w_state_nx  = ST_SAVE;
        end else if (bus.i_pipe_idle) begin
          w_epc_nx   = bus.i_retire_pc;
          w_state_nx = ST_SAVE;
        end
      end
      ST_SAVE: begin
        w_redirect_nx    = 1'b1;
        w_redirect_pc_nx = w_vec_target;
        w_state_nx       = ST_VECTOR;
      end
      ST_VECTOR: w_state_nx = ST_IDLE;
      ST_RETURN: w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase

    // Outputs are registered, so the CSR writes are staged on entry to SAVE.
    if (w_state_nx == ST_SAVE) begin
      w_mepc_we_nx     = 1'b1;
      w_mcause_we_nx   = 1'b1;
      w_mie_clear_nx   = 1'b1;
      w_mepc_data_nx   = {w_epc_nx[XLEN-1:1], 1'b0};
      w_mcause_data_nx = w_cause_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cause       <= '0;
      r_epc         <= '0;
      r_is_irq      <= 1'b0;
      r_mepc_data   <= '0;
      r_mcause_data <= '0;
      r_redirect_pc <= '0;
      r_mepc_we     <= 1'b0;
      r_mcause_we   <= 1'b0;
      r_mie_clear   <= 1'b0;
      r_mie_restore <= 1'b0;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cause       <= w_cause_nx;
      r_epc         <= w_epc_nx;
      r_is_irq      <= w_is_irq_nx;
      r_mepc_data   <= w_mepc_data_nx;
      r_mcause_data <= w_mcause_data_nx;
      r_redirect_pc <= w_redirect_pc_nx;
      r_mepc_we     <= w_mepc_we_nx;
      r_mcause_we   <= w_mcause_we_nx;
      r_mie_clear   <= w_mie_clear_nx;
      r_mie_restore <= w_mie_restore_nx;
      r_stall       <= w_stall_nx;
      r_flush       <= w_flush_nx;
      r_redirect    <= w_redirect_nx;
      r_busy        <= (w_state_nx != ST_IDLE);
    end
  end

  assign bus.o_mepc_data   = r_mepc_data;
  assign bus.o_mepc_we     = r_mepc_we;
  assign bus.o_mcause_data = r_mcause_data;
  assign bus.o_mcause_we   = r_mcause_we;
  assign bus.o_mie_clear   = r_mie_clear;
  assign bus.o_mie_restore = r_mie_restore;
  assign bus.o_stall       = r_stall;
  assign bus.o_flush       = r_flush;
  assign bus.o_redirect    = r_redirect;
  assign bus.o_redirect_pc = r_redirect_pc;
  assign bus.o_busy        = r_busy;
endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed self-checking bench for trap_controller
module tb_trap_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  trap_controller_if #(.XLEN(64), .CAUSE_W(6)) bus ();

  trap_controller #(.XLEN(64), .CAUSE_W(6)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mepc_we"},   64'(bus.o_mepc_we),     64'd0);
    chk({tag, "_mcause_we"}, 64'(bus.o_mcause_we),   64'd0);
    chk({tag, "_mie_clear"}, 64'(bus.o_mie_clear),   64'd0);
    chk({tag, "_restore"},   64'(bus.o_mie_restore), 64'd0);
    chk({tag, "_redirect"},  64'(bus.o_redirect),    64'd0);
    chk({tag, "_busy"},      64'(bus.o_busy),        64'd0);
  endtask

  initial begin
    bus.i_exc_valid   = 1'b0;
    bus.i_exc_cause   = '0;
    bus.i_exc_pc      = '0;
    bus.i_mret        = 1'b0;
    bus.i_retire_pc   = '0;
    bus.i_pipe_idle   = 1'b1;
    bus.i_halted      = 1'b0;
    bus.i_mtvec       = '0;
    bus.i_mepc        = '0;
    bus.i_mie         = '0;
    bus.i_mip         = '0;
    bus.i_mstatus_mie = 1'b0;

    // Reset with an exception presented
    rst = 1'b1;
    bus.i_exc_valid = 1'b1;
    bus.i_exc_cause = 6'd11;
    tick();
    tick();
    chk_idle_outputs("rst");
    chk("rst_mepc_data",   bus.o_mepc_data,   64'd0);
    chk("rst_mcause_data", bus.o_mcause_data, 64'd0);
    chk("rst_redir_pc",    bus.o_redirect_pc, 64'd0);
    chk("rst_stall",       64'(bus.o_stall),  64'd0);
    chk("rst_flush",       64'(bus.o_flush),  64'd0);
    bus.i_exc_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk_idle_outputs("post_rst");

    // ECALL-M exception
    bus.i_mtvec     = 64'h100;
    bus.i_exc_valid = 1'b1;
    bus.i_exc_cause = 6'd11;
    bus.i_exc_pc    = 64'h8000_0010;
    tick();
    bus.i_exc_valid = 1'b0;
    chk("ex_mepc_we",     64'(bus.o_mepc_we),     64'd1);
    chk("ex_mcause_we",   64'(bus.o_mcause_we),   64'd1);
    chk("ex_mie_clear",   64'(bus.o_mie_clear),   64'd1);
    chk("ex_mepc_data",   bus.o_mepc_data,        64'h8000_0010);
    chk("ex_mcause_data", bus.o_mcause_data,      64'hB);
    chk("ex_flush",       64'(bus.o_flush),       64'd1);
    chk("ex_stall",       64'(bus.o_stall),       64'd1);
    chk("ex_no_redir",    64'(bus.o_redirect),    64'd0);
    chk("ex_busy",        64'(bus.o_busy),        64'd1);
    tick();
    chk("ex_redirect",    64'(bus.o_redirect),    64'd1);
    chk("ex_redir_pc",    bus.o_redirect_pc,      64'h100);
    chk("ex_we_onecyc",   64'(bus.o_mepc_we),     64'd0);
    chk("ex_stall_rel",   64'(bus.o_stall),       64'd0);
    tick();
    chk_idle_outputs("ex_done");

    // Timer interrupt, vectored mtvec, pipeline busy for three cycles
    bus.i_mtvec       = 64'h201;
    bus.i_mie         = 64'h80;
    bus.i_mip         = 64'h80;
    bus.i_mstatus_mie = 1'b1;
    bus.i_pipe_idle   = 1'b0;
    bus.i_retire_pc   = 64'h400;
    tick();
    bus.i_mstatus_mie = 1'b0;
    bus.i_mip         = 64'h0;
    chk("irq_stall0",  64'(bus.o_stall),   64'd1);
    chk("irq_busy0",   64'(bus.o_busy),    64'd1);
    chk("irq_noflush", 64'(bus.o_flush),   64'd0);
    chk("irq_nowe0",   64'(bus.o_mepc_we), 64'd0);
    tick();
    chk("irq_stall1",  64'(bus.o_stall),   64'd1);
    chk("irq_nowe1",   64'(bus.o_mepc_we), 64'd0);
    tick();
    chk("irq_stall2",  64'(bus.o_stall),   64'd1);
    bus.i_pipe_idle = 1'b1;
    tick();
    chk("irq_mepc_we",   64'(bus.o_mepc_we),   64'd1);
    chk("irq_mie_clear", 64'(bus.o_mie_clear), 64'd1);
    chk("irq_mcause",    bus.o_mcause_data,    64'h8000_0000_0000_0007);
    chk("irq_mepc",      bus.o_mepc_data,      64'h400);
    chk("irq_stall3",    64'(bus.o_stall),     64'd1);
    tick();
    chk("irq_redirect",  64'(bus.o_redirect),  64'd1);
    chk("irq_redir_pc",  bus.o_redirect_pc,    64'h21C);
    tick();
    chk_idle_outputs("irq_done");

    // MRET
    bus.i_mepc = 64'h1234;
    bus.i_mret = 1'b1;
    tick();
    bus.i_mret = 1'b0;
    chk("mret_restore",  64'(bus.o_mie_restore), 64'd1);
    chk("mret_redirect", 64'(bus.o_redirect),    64'd1);
    chk("mret_pc",       bus.o_redirect_pc,      64'h1234);
    chk("mret_no_we",    64'(bus.o_mepc_we),     64'd0);
    chk("mret_busy",     64'(bus.o_busy),        64'd1);
    tick();
    chk_idle_outputs("mret_done");

    // Exception + MRET + pending interrupt together; odd PC, vectored mtvec
    bus.i_mtvec       = 64'h301;
    bus.i_mie         = 64'h80;
    bus.i_mip         = 64'h80;
    bus.i_mstatus_mie = 1'b1;
    bus.i_exc_valid   = 1'b1;
    bus.i_exc_cause   = 6'd2;
    bus.i_exc_pc      = 64'h2001;
    bus.i_mret        = 1'b1;
    tick();
    bus.i_exc_valid   = 1'b0;
    bus.i_mret        = 1'b0;
    bus.i_mstatus_mie = 1'b0;
    chk("pri_mcause_we", 64'(bus.o_mcause_we),   64'd1);
    chk("pri_mcause",    bus.o_mcause_data,      64'd2);
    chk("pri_mepc",      bus.o_mepc_data,        64'h2000);
    chk("pri_restore",   64'(bus.o_mie_restore), 64'd0);
    tick();
    chk("pri_redir_pc",  bus.o_redirect_pc,      64'h300);
    chk("pri_restore2",  64'(bus.o_mie_restore), 64'd0);
    tick();
    chk_idle_outputs("pri_done");

    // Debug halt blocks a pending exception until released
    bus.i_mtvec     = 64'h100;
    bus.i_halted    = 1'b1;
    bus.i_exc_valid = 1'b1;
    bus.i_exc_cause = 6'd3;
    bus.i_exc_pc    = 64'h3000;
    tick();
    chk_idle_outputs("halt0");
    tick();
    chk_idle_outputs("halt1");
    bus.i_halted = 1'b0;
    tick();
    bus.i_exc_valid = 1'b0;
    chk("halt_mepc_we", 64'(bus.o_mepc_we), 64'd1);
    chk("halt_mcause",  bus.o_mcause_data,  64'd3);
    chk("halt_mepc",    bus.o_mepc_data,    64'h3000);
    tick();
    chk("halt_redir_pc", bus.o_redirect_pc, 64'h100);
    tick();

    // Exception arriving while draining an interrupt takes over
    bus.i_mtvec       = 64'h201;
    bus.i_mstatus_mie = 1'b1;
    bus.i_pipe_idle   = 1'b0;
    tick();
    bus.i_mstatus_mie = 1'b0;
    chk("drx_stall", 64'(bus.o_stall), 64'd1);
    bus.i_exc_valid = 1'b1;
    bus.i_exc_cause = 6'd2;
    bus.i_exc_pc    = 64'h5000;
    tick();
    bus.i_exc_valid = 1'b0;
    bus.i_pipe_idle = 1'b1;
    chk("drx_mcause", bus.o_mcause_data, 64'd2);
    chk("drx_mepc",   bus.o_mepc_data,   64'h5000);
    chk("drx_flush",  64'(bus.o_flush),  64'd1);
    tick();
    chk("drx_redir_pc", bus.o_redirect_pc, 64'h200);
    tick();
    chk_idle_outputs("drx_done");

    // Reset in the middle of a trap
    bus.i_exc_valid = 1'b1;
    bus.i_exc_cause = 6'd11;
    bus.i_exc_pc    = 64'h6000;
    tick();
    bus.i_exc_valid = 1'b0;
    chk("mid_we_pre", 64'(bus.o_mepc_we), 64'd1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_rst");
    chk("mid_stall", 64'(bus.o_stall), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("mid_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequences trap entry and return for the core by driving the CSR file's side-channel write ports (mepc/mcause write strobes, mie clear/restore) and issuing a PC redirect to fetch.
- Arbitrates between synchronous exceptions, the machine timer interrupt and MRET, with a defined priority.
- Honours debug halt.
- Sits between the execute/retire stage and the CSR file.

Parameters:
- XLEN, 64, data/address width.
- CAUSE_W, 6, width of exception code field supplied by the pipeline.

Ports:
- i_clk  in  1  core clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_exc_valid  in  1  synchronous exception reported by retiring instruction
- i_exc_cause  in  CAUSE_W  exception code (e.g. 2 illegal, 3 ebreak, 11 ecall-M)
- i_exc_pc  in  XLEN  PC of faulting instruction
- i_mret  in  1  retiring instruction is MRET
- i_retire_pc  in  XLEN  PC of next instruction to execute (interrupt return point)
- i_pipe_idle  in  1  no instruction in flight past decode
- i_halted  in  1  debug halt active
- i_mtvec  in  XLEN  from CSR file
- i_mepc  in  XLEN  from CSR file
- i_mie  in  XLEN  from CSR file
- i_mip  in  XLEN  from CSR file
- i_mstatus_mie  in  1  from CSR file
- o_mepc_data  out  XLEN  value for CSR file mepc write
- o_mepc_we  out  1  one-cycle strobe
- o_mcause_data  out  XLEN  value for CSR file mcause write
- o_mcause_we  out  1  one-cycle strobe
- o_mie_clear  out  1  one-cycle strobe
- o_mie_restore  out  1  one-cycle strobe
- o_stall  out  1  hold fetch/decode
- o_flush  out  1  squash younger instructions
- o_redirect  out  1  one-cycle strobe: fetch from o_redirect_pc
- o_redirect_pc  out  XLEN  target PC
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async): state=IDLE; all outputs 0, including data buses.
- States: IDLE, DRAIN, SAVE, VECTOR, RETURN. All outputs are registered.
- IDLE:
  - Priority: i_halted (stay IDLE, no action) > i_exc_valid > i_mret > pending interrupt.
  - Pending interrupt = i_mstatus_mie & |(i_mie & i_mip); only bit 7 (MTI) is supported, cause code 7.
  - Exception: latch cause={0,zero-ext i_exc_cause}, epc=i_exc_pc, is_irq=0; assert o_flush+o_stall; go SAVE.
  - MRET: assert o_flush+o_stall; go RETURN.
  - Interrupt: latch cause={1,0..,7}, is_irq=1; assert o_stall; go DRAIN.
- DRAIN:
  - Hold o_stall.
  - When i_pipe_idle: latch epc=i_retire_pc, go SAVE.
  - If i_exc_valid arrives while draining: the exception wins, its cause/pc replace the interrupt's, go SAVE (interrupt re-evaluated later).
- SAVE (1 cycle):
  - o_mepc_data={epc[63:1],0}, o_mcause_data=cause, o_mepc_we=o_mcause_we=o_mie_clear=1.
  - Go VECTOR.
- VECTOR (1 cycle):
  - o_redirect=1.
  - o_redirect_pc = {mtvec[63:2],00} if mtvec[1:0]!=1 or !is_irq; otherwise {mtvec[63:2],00}+4*cause_code (64-bit add, wrap ignored).
  - Release stall; go IDLE.
- RETURN (1 cycle):
  - o_mie_restore=1, o_redirect=1, o_redirect_pc=i_mepc.
  - Go IDLE.
- Strobes are high exactly one cycle. The CSR file samples them on the following falling edge.
- Latency: exception in cycle N → SAVE strobes N+1 → redirect N+2. MRET in N → redirect N+1.
- No new trap is accepted until back in IDLE.
- An interrupt whose enable drops during DRAIN is still taken (already committed).
- i_halted asserting mid-sequence does not abort; the halt is honoured on return to IDLE.
- Reset mid-sequence returns to IDLE with no strobes.

Decomposition:
- Shared package trap_pkg holds:
  - state enum
  - cause code constants (CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11, IRQ_MTI=7)
  - MTVEC_MODE_VECTORED=1
- Optional sub-module trap_vector_calc (combinational target PC from mtvec, cause, is_irq). Everything else stays in one module.

Test Plan:
- Reset: pulse i_reset with i_exc_valid=1 → all outputs 0, state IDLE, no strobes.
- Exception, cause=11, pc=0x8000_0010, mtvec=0x100:
  - N+1: mepc_we/mcause_we/mie_clear with data 0x8000_0010 / 0xB.
  - N+2: redirect to 0x100.
- Timer interrupt, mie[7]=mip[7]=mstatus_mie=1, mtvec=0x201 (vectored), i_pipe_idle low 3 cycles, retire_pc=0x400:
  - stall held through the drain.
  - mcause=0x8000_0000_0000_0007, mepc=0x400.
  - redirect 0x21C.
- MRET with i_mepc=0x1234 → next cycle mie_restore=1, redirect to 0x1234, o_busy low after.
- Simultaneous i_exc_valid (cause 2) and i_mret and pending interrupt → exception path taken, mcause=2, no mie_restore.
- i_halted=1 with i_exc_valid=1 → no strobes, state stays IDLE. Deassert halt with exception still valid → normal trap sequence.
